alu_share_sched: RTL

Round-robin scheduler that shares one 64-bit ALU datapath (add, a−b, b−a, OR, AND, XOR, XNOR) between `NREQ` requesters. Each requester presents operands and a 3-bit opcode on a valid/ready port. The block grants one request per cycle, computes the result and registers it into a single tagged response slot with backpressure. It sits between the issuing engines and the shared arithmetic resource and is the only path into that resource.

---
 rtl/alu_share_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_share_sched.sv
// Round-robin front end for one shared 64-bit ALU: grants one requester per
// cycle and registers the result into a single tagged response slot.
module alu_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  input  logic [3*NREQ-1:0]    req_oper,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [63:0]          resp_sum,
  output logic                 resp_cout,
  output logic                 resp_err
);

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  // A request is accepted only when the slot is empty or draining that same
  // cycle, so a stalled slot never loses or overwrites a result.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t     state;
  logic [IDW-1:0]  ptr;
  logic            accept_ok;
  logic            accept;
  logic            found_hi;
  logic            found_any;
  logic [IDW-1:0]  idx_hi;
  logic [IDW-1:0]  idx_any;
  logic [IDW-1:0]  grant_idx;
  logic [63:0]     a_arr [NREQ];
  logic [63:0]     b_arr [NREQ];
  logic [2:0]      op_arr [NREQ];
  logic [63:0]     op_a;
  logic [63:0]     op_b;
  logic [2:0]      op;
  logic [64:0]     add_res;
  logic [63:0]     alu_sum;
  logic            alu_cout;
  logic            alu_err;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]  = req_a[64*i +: 64];
      b_arr[i]  = req_b[64*i +: 64];
      op_arr[i] = req_oper[3*i +: 3];
    end
  end

  // Lowest valid index at or above ptr wins; otherwise wrap to lowest valid.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found_any = 1'b1;
        idx_any   = IDW'(i);
        if (i >= int'(ptr)) begin
          found_hi = 1'b1;
          idx_hi   = IDW'(i);
        end
      end
    end
    grant_idx = found_hi ? idx_hi : idx_any;
  end

  assign accept_ok = (state == EMPTY) || resp_ready;
  assign accept    = accept_ok && found_any && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    op_a     = a_arr[grant_idx];
    op_b     = b_arr[grant_idx];
    op       = op_arr[grant_idx];
    add_res  = '0;
    alu_sum  = '0;
    alu_cout = 1'b0;
    alu_err  = 1'b0;
    case (op)
      3'b000:  add_res = {1'b0, op_a} + {1'b0, op_b};
      3'b001:  add_res = {1'b0, op_a} + {1'b0, ~op_b} + 65'd1;
      3'b010:  add_res = {1'b0, op_b} + {1'b0, ~op_a} + 65'd1;
      3'b011:  alu_sum = op_a | op_b;
      3'b100:  alu_sum = op_a & op_b;
      3'b101:  alu_sum = op_a ^ op_b;
      3'b110:  alu_sum = ~(op_a ^ op_b);
      default: alu_err = 1'b1;
    endcase
    if (op <= 3'b010) begin
      alu_sum  = add_res[63:0];
      alu_cout = add_res[64];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ptr       <= '0;
      resp_id   <= '0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      state     <= FULL;
      ptr       <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      resp_id   <= grant_idx;
      resp_sum  <= alu_sum;
      resp_cout <= alu_cout;
      resp_err  <= alu_err;
    end else if (resp_ready) begin
      state <= EMPTY;
    end
  end

  assign resp_valid = (state == FULL);

endmodule
